// File: rtl/game_result_tracker_pkg.sv
// Shared constants and state encoding for the match outcome tracker.
package game_result_tracker_pkg;

  localparam logic [1:0] GE_RUN  = 2'd0;
  localparam logic [1:0] GE_WIN  = 2'd1;
  localparam logic [1:0] GE_LOSE = 2'd2;
  localparam logic [1:0] GE_DRAW = 2'd3;

  localparam int MAX_HP_DEF       = 5;
  localparam int HIT_COOLDOWN_DEF = 30;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_PENDING = 3'd2,
    ST_WIN     = 3'd3,
    ST_LOSE    = 3'd4,
    ST_DRAW    = 3'd5
  } state_t;

endpackage

// File: rtl/game_result_tracker_tank_hp_counter.sv
// Per-tank hit points with a frame-counted invulnerability window after each accepted hit.
module tank_hp_counter
  import game_result_tracker_pkg::*;
#(
  parameter int MAX_HP       = MAX_HP_DEF,
  parameter int HIT_COOLDOWN = HIT_COOLDOWN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       hit,
  input  logic       frame_tick,
  output logic [2:0] hp,
  output logic       dead
);

  logic [5:0] cooldown;
  logic       accept;

  assign accept = enable & hit & (cooldown == 6'd0) & (hp != 3'd0);
  assign dead   = (hp == 3'd0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hp       <= 3'(MAX_HP);
      cooldown <= 6'd0;
    end else if (enable) begin
      // A hit reload takes precedence over a frame decrement in the same cycle.
      if (accept) begin
        hp       <= hp - 3'd1;
        cooldown <= 6'(HIT_COOLDOWN);
      end else if (frame_tick && cooldown != 6'd0) begin
        cooldown <= cooldown - 6'd1;
      end
    end
  end

endmodule

// File: rtl/game_result_tracker.sv
// Match outcome FSM: tracks both tanks' hp and publishes game_end on frame boundaries.
// Optional macro GAME_RESULT_DRAW_EN turns a double kill into DRAW (game_end=3) instead of LOSE.
module game_result_tracker
  import game_result_tracker_pkg::*;
#(
  parameter int MAX_HP       = MAX_HP_DEF,
  parameter int HIT_COOLDOWN = HIT_COOLDOWN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       select,
  input  logic       vblnk,
  input  logic       hit_player,
  input  logic       hit_enemy,
  input  logic       back_to_menu,
  output logic [1:0] game_end,
  output logic [2:0] hp_player,
  output logic [2:0] hp_enemy,
  output logic       freeze
);

  state_t state;
  logic   vblnk_d;
  logic   frame_tick;
  logic   exit_req;
  logic   hp_clear;
  logic   hp_enable;
  logic   dead_player;
  logic   dead_enemy;

  assign frame_tick = vblnk & ~vblnk_d;
  assign exit_req   = (state != ST_IDLE) & (back_to_menu | ~select);
  // Clearing on the exit cycle itself restores hp together with the IDLE transition.
  assign hp_clear   = (state == ST_IDLE) | exit_req;
  assign hp_enable  = (state == ST_PLAY);

  tank_hp_counter #(
    .MAX_HP       (MAX_HP),
    .HIT_COOLDOWN (HIT_COOLDOWN)
  ) u_player (
    .clk        (clk),
    .rst        (rst),
    .clear      (hp_clear),
    .enable     (hp_enable),
    .hit        (hit_player),
    .frame_tick (frame_tick),
    .hp         (hp_player),
    .dead       (dead_player)
  );

  tank_hp_counter #(
    .MAX_HP       (MAX_HP),
    .HIT_COOLDOWN (HIT_COOLDOWN)
  ) u_enemy (
    .clk        (clk),
    .rst        (rst),
    .clear      (hp_clear),
    .enable     (hp_enable),
    .hit        (hit_enemy),
    .frame_tick (frame_tick),
    .hp         (hp_enemy),
    .dead       (dead_enemy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      game_end <= GE_RUN;
      freeze   <= 1'b1;
      vblnk_d  <= 1'b0;
    end else begin
      vblnk_d <= vblnk;
      if (exit_req) begin
        state    <= ST_IDLE;
        game_end <= GE_RUN;
        freeze   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            game_end <= GE_RUN;
            if (select) begin
              state  <= ST_PLAY;
              freeze <= 1'b0;
            end else begin
              freeze <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (dead_player || dead_enemy) begin
              state  <= ST_PENDING;
              freeze <= 1'b1;
            end
          end
          ST_PENDING: begin
            // Outcome is committed only on a frame boundary.
            if (frame_tick) begin
`ifdef GAME_RESULT_DRAW_EN
              if (dead_player && dead_enemy) begin
                state    <= ST_DRAW;
                game_end <= GE_DRAW;
              end else
`endif
              if (dead_player) begin
                state    <= ST_LOSE;
                game_end <= GE_LOSE;
              end else begin
                state    <= ST_WIN;
                game_end <= GE_WIN;
              end
            end
          end
          default: begin
            freeze <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_result_tracker.sv
// Directed bench for game_result_tracker with hand-computed expectations.
module tb_game_result_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       select = 1'b0;
  logic       vblnk = 1'b0;
  logic       hit_player = 1'b0;
  logic       hit_enemy = 1'b0;
  logic       back_to_menu = 1'b0;
  logic [1:0] game_end;
  logic [2:0] hp_player;
  logic [2:0] hp_enemy;
  logic       freeze;

  int total = 0;
  int bad   = 0;
  int exp_double;

  game_result_tracker #(.MAX_HP(5), .HIT_COOLDOWN(30)) dut (
    .clk          (clk),
    .rst          (rst),
    .select       (select),
    .vblnk        (vblnk),
    .hit_player   (hit_player),
    .hit_enemy    (hit_enemy),
    .back_to_menu (back_to_menu),
    .game_end     (game_end),
    .hp_player    (hp_player),
    .hp_enemy     (hp_enemy),
    .freeze       (freeze)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vblnk = 1'b1;
    step();
    vblnk = 1'b0;
    step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse(input logic p, input logic e);
    hit_player = p;
    hit_enemy  = e;
    step();
    hit_player = 1'b0;
    hit_enemy  = 1'b0;
  endtask

  task automatic menu_pulse();
    back_to_menu = 1'b1;
    step();
    back_to_menu = 1'b0;
  endtask

  initial begin
`ifdef GAME_RESULT_DRAW_EN
    exp_double = 3;
`else
    exp_double = 2;
`endif
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_game_end", game_end, 0);
    check("rst_hp_player", hp_player, 5);
    check("rst_hp_enemy", hp_enemy, 5);
    check("rst_freeze", freeze, 1);

    select = 1'b1;
    step();
    check("play_freeze", freeze, 0);
    check("play_hp_player", hp_player, 5);
    check("play_hp_enemy", hp_enemy, 5);
    check("play_game_end", game_end, 0);

    // Cooldown: second hit 10 cycles later is rejected.
    pulse(1'b0, 1'b1);
    check("hit1_hp_enemy", hp_enemy, 4);
    repeat (9) step();
    pulse(1'b0, 1'b1);
    check("cooldown_reject", hp_enemy, 4);
    frames(29);
    pulse(1'b0, 1'b1);
    check("cooldown_29_reject", hp_enemy, 4);
    frame();
    pulse(1'b0, 1'b1);
    check("cooldown_30_accept", hp_enemy, 3);

    // Same-cycle hit and frame tick: reload wins, so 29 more frames are not enough.
    frames(30);
    vblnk = 1'b1;
    hit_enemy = 1'b1;
    step();
    hit_enemy = 1'b0;
    vblnk = 1'b0;
    step();
    check("hit_with_tick", hp_enemy, 2);
    frames(29);
    pulse(1'b0, 1'b1);
    check("reload_wins", hp_enemy, 2);
    frame();
    pulse(1'b0, 1'b1);
    check("hit4_hp_enemy", hp_enemy, 1);
    frames(30);
    pulse(1'b0, 1'b1);
    check("kill_hp_enemy", hp_enemy, 0);
    check("kill_freeze_still_play", freeze, 0);
    step();
    check("pending_freeze", freeze, 1);
    repeat (99) step();
    check("pending_game_end", game_end, 0);
    pulse(1'b1, 1'b0);
    check("pending_hit_ignored", hp_player, 5);
    vblnk = 1'b1;
    #1;
    check("before_edge_game_end", game_end, 0);
    step();
    vblnk = 1'b0;
    check("win_game_end", game_end, 1);
    check("win_freeze", freeze, 1);
    pulse(1'b1, 1'b0);
    check("win_hit_ignored", hp_player, 5);
    step();
    check("win_hold", game_end, 1);

    menu_pulse();
    check("menu_game_end", game_end, 0);
    check("menu_hp_enemy", hp_enemy, 5);
    check("menu_freeze", freeze, 1);
    step();
    check("replay_freeze", freeze, 0);

    // Double kill.
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b1);
      frames(30);
    end
    check("both_hp_player_1", hp_player, 1);
    check("both_hp_enemy_1", hp_enemy, 1);
    pulse(1'b1, 1'b1);
    check("both_hp_player_0", hp_player, 0);
    check("both_hp_enemy_0", hp_enemy, 0);
    step();
    check("both_freeze", freeze, 1);
    check("both_pending", game_end, 0);
    frame();
    check("double_kill_game_end", game_end, exp_double);

    menu_pulse();
    check("exit_game_end", game_end, 0);
    check("exit_hp_player", hp_player, 5);
    check("exit_hp_enemy", hp_enemy, 5);
    step();
    check("replay2_freeze", freeze, 0);

    // Drop select mid-match.
    pulse(1'b1, 1'b0);
    frames(30);
    pulse(1'b1, 1'b0);
    frames(30);
    pulse(1'b1, 1'b0);
    check("mid_hp_player", hp_player, 2);
    select = 1'b0;
    step();
    check("desel_hp_player", hp_player, 5);
    check("desel_freeze", freeze, 1);
    check("desel_game_end", game_end, 0);
    pulse(1'b1, 1'b0);
    check("idle_hit_ignored", hp_player, 5);

    // Reset mid-match.
    select = 1'b1;
    step();
    pulse(1'b0, 1'b1);
    check("pre_rst_hp_enemy", hp_enemy, 4);
    rst = 1'b1;
    step();
    check("mid_rst_hp_enemy", hp_enemy, 5);
    check("mid_rst_freeze", freeze, 1);
    rst = 1'b0;
    step();
    check("post_rst_play", freeze, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
